// File: rtl/ocm_dma_pkg.sv
// ============================================================================
//  Module      : ocm_dma_pkg
//  Description : Shared types and default sizes for the worker OCM DMA.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package ocm_dma_pkg;

    localparam int OCM_ADDR_W = 7;
    localparam int OCM_DATA_W = 32;
    localparam int OCM_LEN_W  = 8;
    localparam int OCM_DEPTH  = 2 ** OCM_ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/system_worker_ocm_dma_if.sv
// ============================================================================
//  Module      : system_worker_ocm_dma_if
//  Description : Command, stream and Avalon-MM OCM signals of the OCM DMA.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

interface system_worker_ocm_dma_if
    import ocm_dma_pkg::*;
#(
    parameter int ADDR_W = OCM_ADDR_W,
    parameter int DATA_W = OCM_DATA_W,
    parameter int LEN_W  = OCM_LEN_W
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_W-1:0]     cmd_addr;
    logic [LEN_W-1:0]      cmd_len;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_W-1:0]     wr_data;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [DATA_W-1:0]     rd_data;
    logic                  done;
    logic                  err;
    logic [ADDR_W-1:0]     ocm_address;
    logic [DATA_W/8-1:0]   ocm_byteenable;
    logic                  ocm_chipselect;
    logic                  ocm_write;
    logic [DATA_W-1:0]     ocm_writedata;
    logic [DATA_W-1:0]     ocm_readdata;
    logic                  ocm_clken;

    // DMA engine side
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  wr_valid, wr_data, rd_ready, ocm_readdata,
        output cmd_ready, wr_ready, rd_valid, rd_data, done, err,
        output ocm_address, ocm_byteenable, ocm_chipselect, ocm_write,
        output ocm_writedata, ocm_clken
    );

    // Host controller and OCM side
    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        output wr_valid, wr_data, rd_ready, ocm_readdata,
        input  cmd_ready, wr_ready, rd_valid, rd_data, done, err,
        input  ocm_address, ocm_byteenable, ocm_chipselect, ocm_write,
        input  ocm_writedata, ocm_clken
    );
endinterface

`default_nettype wire

// File: rtl/ocm_dma_skid.sv
// ============================================================================
//  Module      : ocm_dma_skid
//  Description : 2-entry first-word-fall-through buffer for OCM read returns.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module ocm_dma_skid #(
    parameter int DATA_W = 32
) (
    input  wire logic              clk,
    input  wire logic              reset_n,
    input  wire logic              i_push,
    input  wire logic [DATA_W-1:0] i_data,
    input  wire logic              i_pop,
    output logic [1:0]             o_count,
    output logic [DATA_W-1:0]      o_data
);
    logic [DATA_W-1:0] r_mem [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;

    // Caller guarantees no push when full and no pop when empty
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

endmodule

`default_nettype wire

// File: rtl/system_worker_ocm_dma.sv
// ============================================================================
//  Module      : system_worker_ocm_dma
//  Description : Block DMA between a host stream and a worker's single-port
//                OCM. Optional running checksum: OCM_DMA_CHECKSUM_EN.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module system_worker_ocm_dma
    import ocm_dma_pkg::*;
#(
    parameter int ADDR_W = OCM_ADDR_W,
    parameter int DATA_W = OCM_DATA_W,
    parameter int LEN_W  = OCM_LEN_W
) (
    input  wire logic               clk,
    input  wire logic               reset_n,
`ifdef OCM_DMA_CHECKSUM_EN
    output logic [DATA_W-1:0]       csum,
`endif
    system_worker_ocm_dma_if.master bus
);
    localparam logic [LEN_W:0] c_depth = (LEN_W+1)'(2 ** ADDR_W);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  r_addr;
    logic [ADDR_W-1:0]  w_addr_nxt;
    logic [LEN_W-1:0]   r_rem;
    logic [LEN_W-1:0]   w_rem_nxt;
    logic               r_inflight;
    logic               r_done;
    logic               r_err;
    logic               w_done_nxt;
    logic               w_err_nxt;
    logic               w_cmd_ready;
    logic               w_wr_ready;
    logic               w_cs;
    logic               w_we;
    logic               w_issue;
    logic               w_pop;
    logic               w_room;
    logic [1:0]         w_count;
    logic [2:0]         w_occ;
    logic [DATA_W-1:0]  w_head;

    ocm_dma_skid #(.DATA_W(DATA_W)) u_skid (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (r_inflight),
        .i_data  (bus.ocm_readdata),
        .i_pop   (w_pop),
        .o_count (w_count),
        .o_data  (w_head)
    );

    assign w_pop  = (w_count != 2'd0) && bus.rd_ready;
    // Counting this cycle's pop lets a new read issue while the buffer drains
    assign w_occ  = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_room = (w_occ < 3'd2);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_rem      <= '0;
            r_inflight <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_addr     <= w_addr_nxt;
            r_rem      <= w_rem_nxt;
            r_inflight <= w_issue;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_rem_nxt   = r_rem;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_cmd_ready = 1'b0;
        w_wr_ready  = 1'b0;
        w_cs        = 1'b0;
        w_we        = 1'b0;
        w_issue     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    if (bus.cmd_len == '0 || {1'b0, bus.cmd_len} > c_depth) begin
                        w_done_nxt = 1'b1;
                        w_err_nxt  = 1'b1;
                    end else begin
                        w_addr_nxt  = bus.cmd_addr;
                        w_rem_nxt   = bus.cmd_len;
                        w_state_nxt = bus.cmd_write ? S_WRITE : S_READ;
                    end
                end
            end
            S_WRITE: begin
                w_wr_ready = 1'b1;
                if (bus.wr_valid) begin
                    w_cs       = 1'b1;
                    w_we       = 1'b1;
                    w_addr_nxt = r_addr + ADDR_W'(1);
                    w_rem_nxt  = r_rem - LEN_W'(1);
                    if (r_rem == LEN_W'(1)) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_READ: begin
                if (w_room) begin
                    w_cs       = 1'b1;
                    w_issue    = 1'b1;
                    w_addr_nxt = r_addr + ADDR_W'(1);
                    w_rem_nxt  = r_rem - LEN_W'(1);
                    if (r_rem == LEN_W'(1)) begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!r_inflight && w_count == 2'd0) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.cmd_ready      = w_cmd_ready;
    assign bus.wr_ready       = w_wr_ready;
    assign bus.rd_valid       = (w_count != 2'd0);
    assign bus.rd_data        = w_head;
    assign bus.done           = r_done;
    assign bus.err            = r_err;
    assign bus.ocm_address    = r_addr;
    assign bus.ocm_byteenable = '1;
    assign bus.ocm_chipselect = w_cs;
    assign bus.ocm_write      = w_we;
    assign bus.ocm_writedata  = w_we ? bus.wr_data : '0;
    assign bus.ocm_clken      = 1'b1;

`ifdef OCM_DMA_CHECKSUM_EN
    logic [DATA_W-1:0] r_csum;
    logic              w_cmd_acc;

    assign w_cmd_acc = w_cmd_ready && bus.cmd_valid;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_csum <= '0;
        end else if (w_cmd_acc) begin
            r_csum <= '0;
        end else if (w_we) begin
            r_csum <= r_csum + bus.wr_data;
        end else if (w_pop) begin
            r_csum <= r_csum + w_head;
        end
    end

    assign csum = r_csum;
`endif

endmodule

`default_nettype wire

// File: tb/tb_system_worker_ocm_dma.sv
// ============================================================================
//  Module      : tb_system_worker_ocm_dma
//  Description : Scoreboard bench for system_worker_ocm_dma with an OCM model.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_system_worker_ocm_dma;
    typedef struct packed {
        logic [6:0]  a;
        logic [31:0] d;
    } wr_t;

    logic clk;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    system_worker_ocm_dma_if #(.ADDR_W(7), .DATA_W(32), .LEN_W(8)) bus ();

`ifdef OCM_DMA_CHECKSUM_EN
    logic [31:0] csum;
`endif

    system_worker_ocm_dma #(.ADDR_W(7), .DATA_W(32), .LEN_W(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
`ifdef OCM_DMA_CHECKSUM_EN
        .csum    (csum),
`endif
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural OCM: single port, read latency 1
    logic [31:0] mem [0:127];
    logic [31:0] rdq;
    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        rdq = 32'h0;
    end
    always @(posedge clk) begin
        if (bus.ocm_chipselect) begin
            if (bus.ocm_write) mem[bus.ocm_address] <= bus.ocm_writedata;
            else               rdq <= mem[bus.ocm_address];
        end
    end
    assign bus.ocm_readdata = rdq;

    wr_t         exp_wr [$];
    logic [31:0] exp_rd [$];
    logic        exp_done [$];
    wr_t         we;
    logic [31:0] re;
    logic        de;
    logic        allow_rd = 1'b0;
    logic        b2b = 1'b0;
    logic        cur_write = 1'b0;
    logic        have_lw = 1'b0, have_lp = 1'b0;
    int          lw = 0, lp = 0, niss = 0, npop = 0;
    logic        rd_mode = 1'b0;
    logic        rd_hold = 1'b1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_ev(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: event observed/missed, expected otherwise", nm);
    endtask

    // rd_ready driver: held level, or the 1,0,0 repeating pattern
    initial begin
        int ph = 0;
        bus.rd_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (rd_mode) begin
                bus.rd_ready = (ph == 0);
                ph = (ph + 1) % 3;
            end else begin
                bus.rd_ready = rd_hold;
                ph = 0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents an output event
    always @(negedge clk) begin
        if (bus.ocm_chipselect && bus.ocm_write) begin
            if (exp_wr.size() == 0) fail_ev("unexpected_ocm_write");
            else begin
                we = exp_wr.pop_front();
                chk("wr_addr", 64'(bus.ocm_address), 64'(we.a));
                chk("wr_data", 64'(bus.ocm_writedata), 64'(we.d));
                if (b2b && have_lw) chk("wr_back_to_back", 64'(cyc), 64'(lw + 1));
                have_lw = 1'b1;
                lw = cyc;
            end
        end
        if (bus.ocm_chipselect && !bus.ocm_write) begin
            if (!allow_rd) fail_ev("unexpected_ocm_read");
            else niss++;
        end
        if (bus.rd_valid && bus.rd_ready) begin
            npop++;
            if (exp_rd.size() == 0) fail_ev("unexpected_rd_word");
            else begin
                re = exp_rd.pop_front();
                chk("rd_data", 64'(bus.rd_data), 64'(re));
                if (b2b && have_lp) chk("rd_back_to_back", 64'(cyc), 64'(lp + 1));
                have_lp = 1'b1;
                lp = cyc;
            end
        end
        if (bus.ocm_chipselect && !bus.ocm_write && allow_rd)
            chk("reads_outstanding_le2", 64'((niss - npop) <= 2), 64'(1));
        if (bus.done) begin
            if (exp_done.size() == 0) fail_ev("unexpected_done");
            else begin
                de = exp_done.pop_front();
                chk("err_with_done", 64'(bus.err), 64'(de));
                if (cur_write && have_lw) chk("done_latency", 64'(cyc), 64'(lw + 1));
            end
        end else if (bus.err) begin
            fail_ev("err_without_done");
        end
    end

    task automatic issue_cmd(input logic w, input logic [6:0] a, input logic [7:0] l);
        int t = 0;
        while (!bus.cmd_ready && t < 100) begin
            @(posedge clk); #1; t++;
        end
        if (t >= 100) fail_ev("cmd_ready_timeout");
        have_lw = 1'b0; have_lp = 1'b0; niss = 0; npop = 0; cur_write = w;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_len   = l;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while ((exp_done.size() != 0 || !bus.cmd_ready) && t < 300) begin
            @(negedge clk); #1; t++;
        end
        if (t >= 300) fail_ev("done_timeout");
        chk("leftover_rd_words", 64'(exp_rd.size()), 64'(0));
        chk("leftover_writes", 64'(exp_wr.size()), 64'(0));
        allow_rd = 1'b0;
        b2b = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_write(input logic [6:0] a, input int l, input logic [31:0] base,
                            input logic [31:0] step);
        for (int i = 0; i < l; i++) exp_wr.push_back('{a: 7'(a + i), d: base + 32'(i) * step});
        exp_done.push_back(1'b0);
        b2b = 1'b1;
        issue_cmd(1'b1, a, 8'(l));
        for (int i = 0; i < l; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = base + 32'(i) * step;
            @(posedge clk); #1;
        end
        bus.wr_valid = 1'b0;
        bus.wr_data  = 32'h0;
    endtask

    task automatic do_read(input logic [6:0] a, input int l, input logic [31:0] base,
                           input logic bb);
        for (int i = 0; i < l; i++) exp_rd.push_back(base + 32'(i));
        exp_done.push_back(1'b0);
        allow_rd = 1'b1;
        b2b = bb;
        issue_cmd(1'b0, a, 8'(l));
    endtask

    task automatic chk_reset_outputs();
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
        chk("rst_rd_valid", 64'(bus.rd_valid), 64'(0));
        chk("rst_wr_ready", 64'(bus.wr_ready), 64'(0));
        chk("rst_done", 64'(bus.done), 64'(0));
        chk("rst_err", 64'(bus.err), 64'(0));
        chk("rst_chipselect", 64'(bus.ocm_chipselect), 64'(0));
        chk("rst_byteenable", 64'(bus.ocm_byteenable), 64'(4'hF));
        chk("rst_clken", 64'(bus.ocm_clken), 64'(1));
    endtask

    initial begin
        int t;
        reset_n = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
        bus.wr_valid = 1'b0; bus.wr_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk_reset_outputs();
        @(posedge clk); #1;
        reset_n = 1'b1;

        do_write(7'h10, 4, 32'hA0, 32'h1);
        wait_done();
        do_read(7'h10, 4, 32'hA0, 1'b1);
        wait_done();

        // Address wrap 0x7F -> 0x00
        do_write(7'h7E, 4, 32'hB0, 32'h1);
        wait_done();
        do_read(7'h7E, 4, 32'hB0, 1'b1);
        wait_done();

        // Backpressure with rd_ready pattern 1,0,0
        do_write(7'h20, 8, 32'hC0, 32'h1);
        wait_done();
        rd_mode = 1'b1;
        do_read(7'h20, 8, 32'hC0, 1'b0);
        wait_done();
        rd_mode = 1'b0;

        // Illegal lengths: done+err, no OCM access
        exp_done.push_back(1'b1);
        issue_cmd(1'b1, 7'h00, 8'd0);
        wait_done();
        exp_done.push_back(1'b1);
        issue_cmd(1'b0, 7'h00, 8'd129);
        wait_done();

        // Reset during a read after two words
        do_read(7'h20, 8, 32'hC0, 1'b0);
        t = 0;
        while (npop < 2 && t < 50) begin
            @(negedge clk); #1; t++;
        end
        if (t >= 50) fail_ev("pop_timeout");
        @(posedge clk); #1;
        reset_n = 1'b0;
        rd_hold = 1'b0;
        @(posedge clk); #1;
        exp_rd.delete();
        exp_done.delete();
        allow_rd = 1'b0;
        @(negedge clk); #1;
        chk_reset_outputs();
        @(posedge clk); #1;
        reset_n = 1'b1;
        rd_hold = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        do_write(7'h05, 1, 32'hD5, 32'h1);
        wait_done();
        do_read(7'h05, 1, 32'hD5, 1'b0);
        wait_done();

`ifdef OCM_DMA_CHECKSUM_EN
        do_write(7'h40, 2, 32'hFFFF_FFFF, 32'h3);
        wait_done();
        chk("csum", 64'(csum), 64'(32'h0000_0001));
`endif

        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
